// File: rtl/conv_chan_pkg.sv
// Shared types and helpers for the coded-symbol channel impairment block.
// Pure declarations: no latency, no flow control.
package conv_chan_pkg;

    typedef enum logic [1:0] {
        CH_OFF      = 2'd0,
        CH_PERIODIC = 2'd1,
        CH_BURST    = 2'd2,
        CH_RANDOM   = 2'd3
    } chan_mode_e;

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Counts set bits among the low w bits of v.
    function automatic int unsigned popcount(input logic [31:0] v, input int unsigned w);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w && v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/chan_lfsr32.sv
// 32-bit Galois LFSR that steps once per enabled cycle; state is visible directly.
// Zero latency on the state output, no flow control.
module chan_lfsr32
    import conv_chan_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/conv_chan_injector.sv
// Corrupts coded symbols with an off/periodic/burst/random XOR mask and counts injected errors.
// One cycle latency, no backpressure: every valid_i symbol appears on valid_o the next cycle.
module conv_chan_injector
    import conv_chan_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_burst_i,
    input  logic [W-1:0]     cfg_mask_i,
    input  logic [7:0]       cfg_rate_i,
    input  logic             cfg_rand_mask_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [W-1:0]     sym_i,
    output logic             valid_o,
    output logic [W-1:0]     sym_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_err_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o
);

    logic [31:0]      lfsr;
    chan_mode_e       mode_in;
    chan_mode_e       mode_q;
    logic [CNT_W-1:0] sym_idx;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] eff_idx;
    logic [CNT_W:0]   idx_inc;
    logic [CNT_W-1:0] next_idx;
    logic [W-1:0]     emask;
    logic             err;
    logic [CNT_W:0]   bit_sum;
    logic             unused_lfsr_hi;

    chan_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (valid_i),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[31:8+W];

    assign mode_in = chan_mode_e'(cfg_mode_i);
    assign per     = (cfg_period_i == '0) ? CNT_W'(1) : cfg_period_i;

    // A mode switch restarts the pattern; a shrunken period that strands the index does too.
    assign eff_idx  = (mode_in != mode_q || sym_idx >= per) ? '0 : sym_idx;
    assign idx_inc  = {1'b0, eff_idx} + (CNT_W+1)'(1);
    assign next_idx = (idx_inc >= {1'b0, per}) ? '0 : idx_inc[CNT_W-1:0];

    always_comb begin
        emask = '0;
        case (mode_in)
            CH_PERIODIC: if (eff_idx == '0)        emask = cfg_mask_i;
            CH_BURST:    if (eff_idx < cfg_burst_i) emask = cfg_mask_i;
            CH_RANDOM: begin
                if (lfsr[7:0] < cfg_rate_i)
                    emask = cfg_rand_mask_i ? lfsr[8 +: W] : cfg_mask_i;
            end
            default:     emask = '0;
        endcase
    end

    assign err     = |emask;
    assign bit_sum = {1'b0, bit_err_ct_o} + (CNT_W+1)'(popcount(32'(emask), W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o      <= 1'b0;
            sym_o        <= '0;
            err_o        <= 1'b0;
            sym_err_ct_o <= '0;
            bit_err_ct_o <= '0;
            sym_idx      <= '0;
            mode_q       <= CH_OFF;
        end else begin
            if (valid_i) begin
                valid_o <= 1'b1;
                sym_o   <= sym_i ^ emask;
                err_o   <= err;
                mode_q  <= mode_in;
                sym_idx <= next_idx;
                if (err) begin
                    if (sym_err_ct_o != '1) sym_err_ct_o <= sym_err_ct_o + CNT_W'(1);
                    bit_err_ct_o <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                end
            end else begin
                valid_o <= 1'b0;
                err_o   <= 1'b0;
            end
            // Clear overrides any count or index update from the same cycle.
            if (clr_i) begin
                sym_err_ct_o <= '0;
                bit_err_ct_o <= '0;
                sym_idx      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_chan_injector.sv
// Directed bench for conv_chan_injector: table of constant-config runs plus hand sequences.
module tb_conv_chan_injector;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg_mode_i;
    logic [15:0] cfg_period_i;
    logic [15:0] cfg_burst_i;
    logic [1:0]  cfg_mask_i;
    logic [7:0]  cfg_rate_i;
    logic        cfg_rand_mask_i;
    logic        clr_i;
    logic        valid_i;
    logic [1:0]  sym_i;

    logic        valid_o, err_o;
    logic [1:0]  sym_o;
    logic [15:0] sym_err_ct_o, bit_err_ct_o;

    logic        s_valid_o, s_err_o;
    logic [1:0]  s_sym_o;
    logic [3:0]  s_sym_err_ct_o, s_bit_err_ct_o;

    conv_chan_injector #(.W(2), .CNT_W(16), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i), .cfg_burst_i(cfg_burst_i),
        .cfg_mask_i(cfg_mask_i), .cfg_rate_i(cfg_rate_i), .cfg_rand_mask_i(cfg_rand_mask_i),
        .clr_i(clr_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
        .sym_err_ct_o(sym_err_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    conv_chan_injector #(.W(2), .CNT_W(4), .LFSR_SEED(SEED)) dut_s (
        .clk(clk), .rst(rst),
        .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i[3:0]), .cfg_burst_i(cfg_burst_i[3:0]),
        .cfg_mask_i(cfg_mask_i), .cfg_rate_i(cfg_rate_i), .cfg_rand_mask_i(cfg_rand_mask_i),
        .clr_i(clr_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(s_valid_o), .sym_o(s_sym_o), .err_o(s_err_o),
        .sym_err_ct_o(s_sym_err_ct_o), .bit_err_ct_o(s_bit_err_ct_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] lf;
    logic [31:0] lf_pre;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, and leave time just past it for sampling.
    task automatic step(input logic v, input logic [1:0] s, input logic c);
        valid_i = v;
        sym_i   = s;
        clr_i   = c;
        lf_pre  = lf;
        @(posedge clk);
        #1;
        if (v) lf = lfsr_next(lf);
        valid_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] m, input int p, input int b, input logic [1:0] mk,
                           input int r, input logic rm);
        cfg_mode_i      = m;
        cfg_period_i    = 16'(p);
        cfg_burst_i     = 16'(b);
        cfg_mask_i      = mk;
        cfg_rate_i      = 8'(r);
        cfg_rand_mask_i = rm;
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         period;
        int         burst;
        logic [1:0] mask;
        int         rate;
        int         nsym;
        int         exp_se;
        int         exp_be;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p, se, be, idx;
        logic e, hit;
        logic [1:0] s_exp, m, last;

        vecs[0] = '{"off",         2'd0, 16, 0, 2'b11,   0,   10,  0,  0};
        vecs[1] = '{"periodic16",  2'd1, 16, 0, 2'b11,   0,   64,  4,  8};
        vecs[2] = '{"burst3",      2'd2,  8, 3, 2'b01,   0,   16,  6,  6};
        vecs[3] = '{"burst0",      2'd2,  8, 0, 2'b01,   0,   16,  0,  0};
        vecs[4] = '{"burst9",      2'd2,  8, 9, 2'b01,   0,   16, 16, 16};
        vecs[5] = '{"rand_rate0",  2'd3, 16, 0, 2'b11,   0, 1000,  0,  0};
        vecs[6] = '{"period0",     2'd1,  0, 0, 2'b10,   0,    5,  5,  5};

        rst = 1'b0;
        valid_i = 1'b0; sym_i = '0; clr_i = 1'b0;
        set_cfg(2'd0, 16, 0, 2'b11, 0, 1'b0);
        lf = SEED; lf_pre = SEED;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {valid_o, err_o, sym_o}, 4'b0000);
        chk("reset_ct",  {sym_err_ct_o, bit_err_ct_o}, 32'h0);
        rst = 1'b1;

        // Constant-config runs, each preceded by a counter/index clear.
        for (int r = 0; r < 7; r++) begin
            set_cfg(vecs[r].mode, vecs[r].period, vecs[r].burst, vecs[r].mask, vecs[r].rate, 1'b0);
            step(1'b0, 2'b00, 1'b1);
            p = (vecs[r].period == 0) ? 1 : vecs[r].period;
            for (int k = 0; k < vecs[r].nsym; k++) begin
                step(1'b1, 2'b01, 1'b0);
                e = 1'b0;
                if (vecs[r].mode == 2'd1) e = ((k % p) == 0);
                if (vecs[r].mode == 2'd2) e = ((k % p) < vecs[r].burst);
                s_exp = e ? (2'b01 ^ vecs[r].mask) : 2'b01;
                chk({vecs[r].name, "_sym"}, {valid_o, err_o, sym_o}, {1'b1, e, s_exp});
            end
            chk({vecs[r].name, "_sym_ct"}, sym_err_ct_o, vecs[r].exp_se);
            chk({vecs[r].name, "_bit_ct"}, bit_err_ct_o, vecs[r].exp_be);
        end

        // Random rate 128, fixed mask: counts must track the reference LFSR exactly.
        set_cfg(2'd3, 16, 0, 2'b11, 128, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        se = 0;
        for (int k = 0; k < 4096; k++) begin
            step(1'b1, 2'b01, 1'b0);
            hit = (lf_pre[7:0] < 8'd128);
            if (hit) se++;
            if (err_o !== hit) chk("rand128_err", err_o, hit);
        end
        chk("rand128_sym_ct", sym_err_ct_o, se);
        chk("rand128_bit_ct", bit_err_ct_o, 2 * se);
        chk("rand128_range", (se >= 1898 && se <= 2198), 1'b1);

        // Random rate 255 with LFSR-derived mask.
        set_cfg(2'd3, 16, 0, 2'b11, 255, 1'b1);
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 2'b01, 1'b0);
            m = (lf_pre[7:0] < 8'd255) ? lf_pre[9:8] : 2'b00;
            chk("rand_lfsr_mask", {valid_o, err_o, sym_o}, {1'b1, (m != 2'b00), 2'b01 ^ m});
        end

        // Gapped valid: corruption follows valid symbols, output holds in gaps.
        set_cfg(2'd1, 4, 0, 2'b11, 0, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 2'b01, 1'b0);
            e = ((k % 4) == 0);
            last = e ? 2'b10 : 2'b01;
            chk("gap_sym", {valid_o, err_o, sym_o}, {1'b1, e, last});
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 2'b11, 1'b0);
                chk("gap_idle", {valid_o, err_o, sym_o}, {1'b0, 1'b0, last});
            end
        end
        chk("gap_sym_ct", sym_err_ct_o, 3);
        chk("gap_bit_ct", bit_err_ct_o, 6);

        // Saturation on the narrow-counter instance; wide one keeps counting.
        set_cfg(2'd1, 1, 0, 2'b11, 0, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b1, 2'b01, 1'b0);
        chk("sat_sym_ct", s_sym_err_ct_o, 4'hF);
        chk("sat_bit_ct", s_bit_err_ct_o, 4'hF);
        chk("wide_sym_ct", sym_err_ct_o, 20);
        chk("wide_bit_ct", bit_err_ct_o, 40);
        step(1'b1, 2'b01, 1'b1);
        chk("clr_valid_sym", {valid_o, err_o, sym_o}, 4'b1110);
        chk("clr_valid_sat_ct", {s_sym_err_ct_o, s_bit_err_ct_o}, 8'h00);
        chk("clr_valid_ct", {sym_err_ct_o, bit_err_ct_o}, 32'h0);

        // Async reset in the middle of a burst run.
        set_cfg(2'd2, 8, 3, 2'b01, 0, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 2'b01, 1'b0);
        chk("pre_rst_ct", sym_err_ct_o, 3);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_out", {valid_o, err_o, sym_o}, 4'b0000);
        chk("async_rst_ct", {sym_err_ct_o, bit_err_ct_o}, 32'h0);
        lf = SEED;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'b01, 1'b0);
            e = (k < 3);
            chk("post_rst_burst", {valid_o, err_o, sym_o}, {1'b1, e, e ? 2'b00 : 2'b01});
        end
        set_cfg(2'd3, 8, 3, 2'b01, 255, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'b01, 1'b0);
            m = (lf_pre[7:0] < 8'd255) ? lf_pre[9:8] : 2'b00;
            chk("post_rst_lfsr", {valid_o, err_o, sym_o}, {1'b1, (m != 2'b00), 2'b01 ^ m});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
